fifo_rst_seq_tmr: RTL and testbench

//  Parametrised, triple-modular-redundant FIFO reset sequencer for the DAQ path, covering NCH channels.

---
 rtl/fifo_rst_seq_tmr_if.sv | 26 ++
 rtl/fifo_rst_seq_tmr.sv | 141 ++++++++++++++
 tb/tb_fifo_rst_seq_tmr.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fifo_rst_seq_tmr_if.sv
// Control/status bundle between DAQ config logic and the FIFO reset sequencer.
// master = config side, slave = sequencer.
interface fifo_rst_seq_tmr_if #(
    parameter int NCH = 7
);
    logic           START;
    logic [NCH-1:0] CH_MASK;
    logic [NCH-1:0] WR_IDLE;
    logic           HALT;
    logic [NCH-1:0] FIFO_RST;
    logic           DONE;
    logic           BUSY;
    logic           TMO_ERR;
    logic           SEU_ERR;
    logic [2:0]     STATE;

    modport master (
        output START, CH_MASK, WR_IDLE,
        input  HALT, FIFO_RST, DONE, BUSY, TMO_ERR, SEU_ERR, STATE
    );

    modport slave (
        input  START, CH_MASK, WR_IDLE,
        output HALT, FIFO_RST, DONE, BUSY, TMO_ERR, SEU_ERR, STATE
    );
endinterface

// File: rtl/fifo_rst_seq_tmr.sv
// TMR FIFO reset sequencer: halt writers, wait idle, pulse per-channel resets,
// pause, then report DONE. All state is triplicated and majority-voted.
module fifo_rst_seq_tmr #(
    parameter int NCH       = 7,
    parameter int CLR_CYC   = 6,
    parameter int RST_CYC   = 11,
    parameter int PAUSE_CYC = 16,
    parameter int QTO_CYC   = 64,
    parameter int CW        = 8
) (
    input logic               CLK,
    input logic               RST,
    fifo_rst_seq_tmr_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PAUSE = 3'd2,
        S_RSTF  = 3'd3,
        S_RUN   = 3'd4
    } state_e;

    logic [2:0]     state_0, state_1, state_2, st_v, st_nx;
    logic [CW-1:0]  cnt_0, cnt_1, cnt_2, cnt_v, cnt_nx;
    logic [NCH-1:0] mask_q [3];
    logic [NCH-1:0] frst_q [3];
    logic           halt_q [3];
    logic           done_q [3];
    logic           busy_q [3];
    logic           tmo_q  [3];
    logic           seu_q  [3];
    logic [NCH-1:0] mask_v, mask_nx, frst_v, frst_nx;
    logic           halt_v, done_v, busy_v, tmo_v, seu_v;
    logic           halt_nx, done_nx, busy_nx, tmo_nx, seu_nx;
    logic           quiet, diff;

    assign st_v   = (state_0 & state_1) | (state_0 & state_2) | (state_1 & state_2);
    assign cnt_v  = (cnt_0 & cnt_1) | (cnt_0 & cnt_2) | (cnt_1 & cnt_2);
    assign mask_v = (mask_q[0] & mask_q[1]) | (mask_q[0] & mask_q[2])
                  | (mask_q[1] & mask_q[2]);
    assign frst_v = (frst_q[0] & frst_q[1]) | (frst_q[0] & frst_q[2])
                  | (frst_q[1] & frst_q[2]);
    assign halt_v = (halt_q[0] & halt_q[1]) | (halt_q[0] & halt_q[2])
                  | (halt_q[1] & halt_q[2]);
    assign done_v = (done_q[0] & done_q[1]) | (done_q[0] & done_q[2])
                  | (done_q[1] & done_q[2]);
    assign busy_v = (busy_q[0] & busy_q[1]) | (busy_q[0] & busy_q[2])
                  | (busy_q[1] & busy_q[2]);
    assign tmo_v  = (tmo_q[0] & tmo_q[1]) | (tmo_q[0] & tmo_q[2])
                  | (tmo_q[1] & tmo_q[2]);
    assign seu_v  = (seu_q[0] & seu_q[1]) | (seu_q[0] & seu_q[2])
                  | (seu_q[1] & seu_q[2]);

    // Only state and counter copies feed the upset detector.
    assign diff = (state_0 != st_v) | (state_1 != st_v) | (state_2 != st_v)
                | (cnt_0 != cnt_v) | (cnt_1 != cnt_v) | (cnt_2 != cnt_v);

    assign quiet = &(bus.WR_IDLE | ~mask_v);

    always_comb begin
        st_nx   = st_v;
        cnt_nx  = cnt_v + CW'(1);
        mask_nx = mask_v;
        tmo_nx  = tmo_v;
        seu_nx  = seu_v | diff;
        unique case (1'b1)
            st_v == S_IDLE: st_nx = S_CLEAR;
            st_v == S_CLEAR: begin
                if (cnt_v >= CW'(CLR_CYC - 1) && quiet) begin
                    st_nx  = S_RSTF;
                    tmo_nx = 1'b0;
                end else if (cnt_v == CW'(QTO_CYC - 1)) begin
                    st_nx  = S_RSTF;
                    tmo_nx = 1'b1;
                end
            end
            st_v == S_RSTF: begin
                if (cnt_v == CW'(RST_CYC - 1)) st_nx = S_PAUSE;
            end
            st_v == S_PAUSE: begin
                if (cnt_v == CW'(PAUSE_CYC - 1)) st_nx = S_RUN;
            end
            st_v == S_RUN: begin
                if (bus.START) st_nx = S_CLEAR;
            end
            default: st_nx = S_IDLE;
        endcase
        if (st_nx != st_v) cnt_nx = '0;
        if (st_nx == S_CLEAR && st_v != S_CLEAR) mask_nx = bus.CH_MASK;
        frst_nx = '0;
        if (st_nx == S_IDLE) frst_nx = '1;
        if (st_nx == S_RSTF) frst_nx = mask_nx;
        done_nx = (st_nx == S_RUN);
        halt_nx = !done_nx;
        busy_nx = !done_nx;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_0 <= S_IDLE;
            state_1 <= S_IDLE;
            state_2 <= S_IDLE;
            cnt_0   <= '0;
            cnt_1   <= '0;
            cnt_2   <= '0;
            for (int i = 0; i < 3; i++) begin
                mask_q[i] <= '1;
                frst_q[i] <= '1;
                halt_q[i] <= 1'b1;
                done_q[i] <= 1'b0;
                busy_q[i] <= 1'b1;
                tmo_q[i]  <= 1'b0;
                seu_q[i]  <= 1'b0;
            end
        end else begin
            state_0 <= st_nx;
            state_1 <= st_nx;
            state_2 <= st_nx;
            cnt_0   <= cnt_nx;
            cnt_1   <= cnt_nx;
            cnt_2   <= cnt_nx;
            for (int i = 0; i < 3; i++) begin
                mask_q[i] <= mask_nx;
                frst_q[i] <= frst_nx;
                halt_q[i] <= halt_nx;
                done_q[i] <= done_nx;
                busy_q[i] <= busy_nx;
                tmo_q[i]  <= tmo_nx;
                seu_q[i]  <= seu_nx;
            end
        end
    end

    assign bus.STATE    = st_v;
    assign bus.FIFO_RST = frst_v;
    assign bus.HALT     = halt_v;
    assign bus.DONE     = done_v;
    assign bus.BUSY     = busy_v;
    assign bus.TMO_ERR  = tmo_v;
    assign bus.SEU_ERR  = seu_v;
endmodule

// File: tb/tb_fifo_rst_seq_tmr.sv
// Directed bench for fifo_rst_seq_tmr: timing, timeout, mask, re-trigger,
// mid-sequence reset and single-copy upset.
module tb_fifo_rst_seq_tmr;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    int         clr_at, done_at, clr_n, rf_n, pz_n, rst_cnt;
    logic [6:0] rst_or;
    logic       tmo_rf, seen_rf, halt_pre;

    fifo_rst_seq_tmr_if #(.NCH(7)) bus ();

    fifo_rst_seq_tmr dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // k counts edges from the first one stepped here; stops at DONE or maxc.
    task automatic run_seq(input logic trig, input int pulse_at,
                           input logic [6:0] mask_after, input int maxc);
        clr_at = 0; done_at = 0; clr_n = 0; rf_n = 0; pz_n = 0;
        rst_cnt = 0; rst_or = '0; tmo_rf = 0; seen_rf = 0; halt_pre = 0;
        for (int k = 1; k <= maxc && done_at == 0; k++) begin
            bus.START = (trig && k == 1) || (k == pulse_at);
            halt_pre = bus.HALT;
            step();
            if (k == 1) bus.CH_MASK = mask_after;
            case (bus.STATE)
                3'd1: begin
                    clr_n++;
                    if (clr_at == 0) clr_at = k;
                end
                3'd3: begin
                    rf_n++;
                    if (!seen_rf) begin
                        seen_rf = 1;
                        tmo_rf = bus.TMO_ERR;
                    end
                end
                3'd2: pz_n++;
                default: ;
            endcase
            if (bus.FIFO_RST != 0) rst_cnt++;
            rst_or = rst_or | bus.FIFO_RST;
            if (bus.DONE) done_at = k;
        end
        bus.START = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        bus.START = 1'b0;
        bus.CH_MASK = 7'h7F;
        bus.WR_IDLE = 7'h7F;
        step();
        step();
        chk("rst_state", 32'(bus.STATE), 32'd0);
        chk("rst_frst", 32'(bus.FIFO_RST), 32'h7F);
        chk("rst_halt", 32'(bus.HALT), 32'd1);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd1);
        chk("rst_tmo", 32'(bus.TMO_ERR), 32'd0);
        chk("rst_seu", 32'(bus.SEU_ERR), 32'd0);

        // 1: full sequence out of reset
        rst = 1'b1;
        run_seq(1'b0, 0, 7'h7F, 60);
        chk("t1_done_at", 32'(done_at), 32'd34);
        chk("t1_clr_at", 32'(clr_at), 32'd1);
        chk("t1_clr_n", 32'(clr_n), 32'd6);
        chk("t1_rf_n", 32'(rf_n), 32'd11);
        chk("t1_pz_n", 32'(pz_n), 32'd16);
        chk("t1_rst_cnt", 32'(rst_cnt), 32'd11);
        chk("t1_rst_or", 32'(rst_or), 32'h7F);
        chk("t1_halt_pre", 32'(halt_pre), 32'd1);
        chk("t1_halt", 32'(bus.HALT), 32'd0);
        chk("t1_busy", 32'(bus.BUSY), 32'd0);
        chk("t1_state", 32'(bus.STATE), 32'd4);
        chk("t1_tmo", 32'(tmo_rf), 32'd0);

        // 2: writers never idle -> 64-cycle Clear timeout
        bus.WR_IDLE = 7'h00;
        run_seq(1'b1, 0, 7'h7F, 120);
        chk("t2_clr_n", 32'(clr_n), 32'd64);
        chk("t2_tmo_rf", 32'(tmo_rf), 32'd1);
        chk("t2_done_at", 32'(done_at), 32'd92);
        chk("t2_rst_or", 32'(rst_or), 32'h7F);
        chk("t2_tmo_sticky", 32'(bus.TMO_ERR), 32'd1);

        // 3: mask 05, masked writers busy, mask changed mid-sequence
        bus.WR_IDLE = 7'h05;
        bus.CH_MASK = 7'h05;
        run_seq(1'b1, 0, 7'h7F, 120);
        chk("t3_clr_at", 32'(clr_at), 32'd1);
        chk("t3_done_len", 32'(done_at - clr_at), 32'd33);
        chk("t3_rst_or", 32'(rst_or), 32'h05);
        chk("t3_rst_cnt", 32'(rst_cnt), 32'd11);
        chk("t3_tmo_clr", 32'(bus.TMO_ERR), 32'd0);

        // all channels masked: full timing, no resets pulsed
        bus.WR_IDLE = 7'h00;
        bus.CH_MASK = 7'h00;
        run_seq(1'b1, 0, 7'h00, 120);
        chk("tm_done_len", 32'(done_at - clr_at), 32'd33);
        chk("tm_rf_n", 32'(rf_n), 32'd11);
        chk("tm_rst_or", 32'(rst_or), 32'h00);

        // 4: START during Pause is ignored
        bus.WR_IDLE = 7'h7F;
        bus.CH_MASK = 7'h7F;
        run_seq(1'b1, 25, 7'h7F, 120);
        chk("t4_done_at", 32'(done_at), 32'd34);
        chk("t4_pz_n", 32'(pz_n), 32'd16);
        for (int i = 0; i < 6; i++) step();
        chk("t4_stay_done", 32'(bus.DONE), 32'd1);
        chk("t4_stay_run", 32'(bus.STATE), 32'd4);

        // 5: reset mid Reset_FIFOs
        bus.CH_MASK = 7'h05;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("t5_in_rf", 32'(bus.STATE), 32'd3);
        chk("t5_rf_val", 32'(bus.FIFO_RST), 32'h05);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t5_state", 32'(bus.STATE), 32'd0);
        chk("t5_frst", 32'(bus.FIFO_RST), 32'h7F);
        chk("t5_halt", 32'(bus.HALT), 32'd1);
        chk("t5_done", 32'(bus.DONE), 32'd0);
        run_seq(1'b0, 0, 7'h05, 60);
        chk("t5_restart", 32'(done_at), 32'd34);
        chk("t5_rst_or", 32'(rst_or), 32'h05);

        // 6: single-copy upset while in Run
        chk("t6_seu_pre", 32'(bus.SEU_ERR), 32'd0);
        force dut.state_2 = 3'd7;
        step();
        release dut.state_2;
        chk("t6_state", 32'(bus.STATE), 32'd4);
        chk("t6_done", 32'(bus.DONE), 32'd1);
        chk("t6_seu", 32'(bus.SEU_ERR), 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("t6_seu_sticky", 32'(bus.SEU_ERR), 32'd1);
        chk("t6_state_late", 32'(bus.STATE), 32'd4);
        chk("t6_done_late", 32'(bus.DONE), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
